singleportram_arbiter: RTL

//  Two-requester arbiter that shares one singleportram instance. Grants at most one

---
 rtl/singleportram_arbiter_if.sv | 32 +++
 rtl/singleportram_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/singleportram_arbiter_if.sv
// Requester-side bundle for the two-port single-port-RAM arbiter.
// The master modport is the requester side; the arbiter takes the slave modport.
interface singleportram_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic             we0;
  logic             we1;
  logic [31:0]      addr0;
  logic [31:0]      addr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             gnt0;
  logic             gnt1;
  logic             rvalid0;
  logic             rvalid1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             err0;
  logic             err1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );
endinterface

// File: rtl/singleportram_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one single-port RAM between two
// requesters; out-of-range accesses are blocked and answered with an error pulse.
module singleportram_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int WORDS = 1024,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  singleportram_arbiter_if.slave bus,
  output logic [31:0]           ram_address,
  output logic [WIDTH-1:0]      ram_din,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [WIDTH-1:0]      ram_dout
);

  localparam int CW = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  // Never address beyond what the RAM's address bits can reach.
  localparam logic [32:0] SPAN  = 33'(1) << DEPTH;
  localparam logic [32:0] LIMIT = (33'(WORDS) < SPAN) ? 33'(WORDS) : SPAN;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lp_q, lp_d;
  logic          rvalid0_q, rvalid1_q;
  logic          err0_q, err1_q;
  logic          zero_q;

  logic          gnt_any;
  logic          w;
  logic          owned;
  logic          owner;
  logic          req_own;
  logic          req_oth;
  logic          we_w;
  logic [31:0]   addr_w;
  logic          in_range;

  assign owned   = (state_q != IDLE);
  assign owner   = (state_q == OWN1);
  assign req_own = owner ? bus.req1 : bus.req0;
  assign req_oth = owner ? bus.req0 : bus.req1;
  assign gnt_any = reset & (bus.req0 | bus.req1);

  always_comb begin
    w       = 1'b0;
    state_d = IDLE;
    cnt_d   = '0;
    lp_d    = lp_q;
    if (owned) begin
      if (req_own && (cnt_q < BURST_C)) w = owner;
      else if (req_oth)                 w = ~owner;
      else                              w = owner;
    end else if (bus.req0 && bus.req1) begin
      w = ~lp_q;
    end else begin
      w = bus.req1;
    end
    if (gnt_any) begin
      state_d = w ? OWN1 : OWN0;
      lp_d    = w;
      cnt_d   = (owned && (w == owner) && (cnt_q < BURST_C)) ? cnt_q + CW'(1) : CW'(1);
    end
  end

  assign we_w     = w ? bus.we1 : bus.we0;
  assign addr_w   = w ? bus.addr1 : bus.addr0;
  assign in_range = ({1'b0, addr_w} < LIMIT);

  assign bus.gnt0  = gnt_any & ~w;
  assign bus.gnt1  = gnt_any & w;
  assign ram_address = gnt_any ? addr_w : '0;
  assign ram_din     = gnt_any ? (w ? bus.wdata1 : bus.wdata0) : '0;
  assign ram_we      = gnt_any & we_w & in_range;
  assign ram_oe      = gnt_any & ~we_w & in_range;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lp_q      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lp_q      <= lp_d;
      rvalid0_q <= bus.gnt0 & ~we_w;
      rvalid1_q <= bus.gnt1 & ~we_w;
      err0_q    <= bus.gnt0 & ~in_range;
      err1_q    <= bus.gnt1 & ~in_range;
      zero_q    <= ~in_range;
    end
  end

  // Responses still in flight when reset is asserted are suppressed at the outputs.
  assign bus.rvalid0 = reset & rvalid0_q;
  assign bus.rvalid1 = reset & rvalid1_q;
  assign bus.err0    = reset & err0_q;
  assign bus.err1    = reset & err1_q;
  assign bus.rdata0  = (reset & rvalid0_q & ~zero_q) ? ram_dout : '0;
  assign bus.rdata1  = (reset & rvalid1_q & ~zero_q) ? ram_dout : '0;

endmodule
